data_confreg: RTL and testbench

DATA_CONFREG -- requirements
Module: data_confreg

---
 rtl/data_confreg_pkg.sv | 20 ++
 rtl/data_confreg_sync2.sv | 22 ++
 rtl/data_confreg.sv | 100 ++++++++++
 tb/tb_data_confreg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/data_confreg_pkg.sv
// data_confreg_pkg: register offsets, window base and byte-lane merge helper for data_confreg.
// Build option: define CONFREG_TIMER_EN to include TIMER, TIMER_CMP and TIMER_STAT.
package data_confreg_pkg;
    localparam logic [15:0] BASE_HI_DEFAULT = 16'hbfaf;
    localparam logic [15:0] OFF_LED         = 16'h0000;
    localparam logic [15:0] OFF_SWITCH      = 16'h0004;
    localparam logic [15:0] OFF_TIMER       = 16'h0008;
    localparam logic [15:0] OFF_TIMER_CMP   = 16'h000c;
    localparam logic [15:0] OFF_TIMER_STAT  = 16'h0010;
    localparam logic [15:0] OFF_SCRATCH     = 16'h0014;
`ifdef CONFREG_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        for (int i = 0; i < 4; i++) merge[8*i +: 8] = we[i] ? wd[8*i +: 8] : old[8*i +: 8];
    endfunction
endpackage

// File: rtl/data_confreg_sync2.sv
// confreg_sync2: generic-width two-flop synchronizer.
// Ports: clk, reset (async, active-high), din (async input), dout (synchronized).
module confreg_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] meta_q, sync_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end
    assign dout = sync_q;
endmodule

// File: rtl/data_confreg.sv
// data_confreg: CPU data-port splitter between data RAM and a small config register window.
// Ports: clk, reset (async, active-high); cpu_en/we/addr/wdata/rdata CPU data port;
// ram_en/ram_we/ram_rdata data RAM side; led, switch, timer_irq board/timer signals.
// Build option: CONFREG_TIMER_EN adds the free-running timer, compare and status flag.
module data_confreg
    import data_confreg_pkg::*;
#(
    parameter logic [15:0] BASE_HI = BASE_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    input  logic [31:0] ram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic        timer_irq
);
    logic        hit, rd, wr;
    logic [15:0] off;
    logic [7:0]  sw_sync;
    logic [15:0] led_q, led_d;
    logic [31:0] scratch_q, scratch_d, rdata_q, rdata_d, rd_val, tmr_rd, led_m, scratch_m;
    logic        sel_q;

    assign hit    = cpu_en && cpu_addr[31:16] == BASE_HI;
    assign off    = cpu_addr[15:0];
    assign rd     = hit && cpu_we == 4'b0;
    assign wr     = hit && cpu_we != 4'b0;
    assign ram_en = cpu_en && !hit;
    assign ram_we = ram_en ? cpu_we : 4'b0;

    confreg_sync2 #(.W(8)) u_sync (.clk(clk), .reset(reset), .din(switch), .dout(sw_sync));

`ifdef CONFREG_TIMER_EN
    logic [31:0] timer_q, timer_d, cmp_q, cmp_d, timer_m, cmp_m;
    logic        stat_q, stat_d;
    always_comb begin
        timer_m = merge(timer_q, cpu_wdata, cpu_we);
        cmp_m   = merge(cmp_q, cpu_wdata, cpu_we);
        // a write to TIMER replaces that cycle's increment
        timer_d = (wr && off == OFF_TIMER) ? timer_m : timer_q + 32'd1;
        cmp_d   = (wr && off == OFF_TIMER_CMP) ? cmp_m : cmp_q;
        // match set has priority over a coincident write-1 clear
        stat_d  = (timer_q == cmp_q && cmp_q != 32'd0) ||
                  (stat_q && !(wr && off == OFF_TIMER_STAT && cpu_we[0] && cpu_wdata[0]));
        tmr_rd  = off == OFF_TIMER ? timer_q :
                  off == OFF_TIMER_CMP ? cmp_q :
                  off == OFF_TIMER_STAT ? {31'b0, stat_q} : 32'b0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            cmp_q   <= '0;
            stat_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            cmp_q   <= cmp_d;
            stat_q  <= stat_d;
        end
    end
    assign timer_irq = stat_q;
`else
    assign tmr_rd    = 32'b0;
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        led_m     = merge({16'b0, led_q}, cpu_wdata, cpu_we);
        scratch_m = merge(scratch_q, cpu_wdata, cpu_we);
        led_d     = (wr && off == OFF_LED) ? led_m[15:0] : led_q;
        scratch_d = (wr && off == OFF_SCRATCH) ? scratch_m : scratch_q;
        rd_val    = off == OFF_LED ? {16'b0, led_q} :
                    off == OFF_SWITCH ? {24'b0, sw_sync} :
                    off == OFF_SCRATCH ? scratch_q : tmr_rd;
        rdata_d   = rd ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            scratch_q <= '0;
            rdata_q   <= '0;
            sel_q     <= 1'b0;
        end else begin
            led_q     <= led_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            sel_q     <= hit;
        end
    end

    assign led       = led_q;
    assign cpu_rdata = sel_q ? rdata_q : ram_rdata;
endmodule

// File: tb/tb_data_confreg.sv
// tb_data_confreg: scoreboard bench for data_confreg; reads queue expectations, a monitor checks them.
module tb_data_confreg;
    logic        clk, reset, cpu_en, timer_irq, ram_en;
    logic [3:0]  cpu_we, ram_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        rd_issue, rd_pend;
    int          tests, fails;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    data_confreg dut (
        .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .led(led), .switch(switch), .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic [3:0] we, input logic [31:0] a,
                       input logic [31:0] wd);
        @(posedge clk);
        #1;
        cpu_en    = en;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        rd_issue  = 1'b0;
    endtask

    task automatic rd(input string n, input logic [31:0] a, input logic [31:0] exp);
        cyc(1'b1, 4'b0, a, 32'h0);
        rd_issue = 1'b1;
        sb.push_back('{name: n, exp: exp});
    endtask

    task automatic idle();
        cyc(1'b0, 4'b0, 32'h0, 32'h0);
    endtask

    always @(posedge clk) rd_pend <= rd_issue;

    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(e.name, cpu_rdata, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; cpu_en = 1'b0; cpu_we = 4'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        ram_rdata = 32'h55; switch = 8'ha5; rd_issue = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", {16'b0, led}, 32'h0);
        chk("rst_irq", {31'b0, timer_irq}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h55);
        reset = 1'b0;
        idle(); idle(); idle();
        // LED write, low two lanes only
        cyc(1'b1, 4'b0011, 32'hbfaf0000, 32'h1234abcd);
        #1;
        chk("led_wr_ram_en", {31'b0, ram_en}, 32'h0);
        chk("led_wr_ram_we", {28'b0, ram_we}, 32'h0);
        idle();
        #1 chk("led_val", {16'b0, led}, 32'h0000abcd);
        // RAM write passes strobes through
        cyc(1'b1, 4'b1010, 32'h1c000010, 32'h11111111);
        #1;
        chk("ram_wr_en", {31'b0, ram_en}, 32'h1);
        chk("ram_wr_we", {28'b0, ram_we}, 32'ha);
        // SCRATCH byte-lane write then read
        cyc(1'b1, 4'b0100, 32'hbfaf0014, 32'hdeadbeef);
        rd("scratch_rd", 32'hbfaf0014, 32'h00ad0000);
        // RAM then SWITCH back-to-back, then back to RAM
        rd("ram_rd", 32'h1c000000, 32'h55);
        rd("switch_rd", 32'hbfaf0004, 32'h000000a5);
        rd("ram_after_cfg", 32'h1c000004, 32'h55);
        rd("led_rd", 32'hbfaf0000, 32'h0000abcd);
        rd("unmapped_rd", 32'hbfaf0018, 32'h0);
        // writes to SWITCH, unmapped offset and upper LED lanes are ignored
        cyc(1'b1, 4'b1111, 32'hbfaf0004, 32'hffffffff);
        cyc(1'b1, 4'b1111, 32'hbfaf0018, 32'hffffffff);
        cyc(1'b1, 4'b1100, 32'hbfaf0000, 32'hffff0000);
        rd("switch_ro", 32'hbfaf0004, 32'h000000a5);
        rd("unmapped_wr", 32'hbfaf0018, 32'h0);
        rd("led_upper_lanes", 32'hbfaf0000, 32'h0000abcd);
        // switch change: synchronized value appears two edges later
        cyc(1'b1, 4'b0, 32'hbfaf0004, 32'h0);
        switch = 8'h3c;
        rd_issue = 1'b1;
        sb.push_back('{name: "sw_lat0", exp: 32'h000000a5});
        rd("sw_lat1", 32'hbfaf0004, 32'h000000a5);
        rd("sw_lat2", 32'hbfaf0004, 32'h0000003c);
`ifdef CONFREG_TIMER_EN
        cyc(1'b1, 4'b1111, 32'hbfaf0008, 32'hfffffffe);
        cyc(1'b1, 4'b1111, 32'hbfaf000c, 32'h00000002);
        rd("timer_rd", 32'hbfaf0008, 32'hffffffff);
        idle();
        #1 chk("irq_pre0", {31'b0, timer_irq}, 32'h0);
        idle();
        cyc(1'b1, 4'b0001, 32'hbfaf0010, 32'h1);
        #1 chk("irq_pre_match", {31'b0, timer_irq}, 32'h0);
        rd("stat_rd", 32'hbfaf0010, 32'h1);
        #1 chk("irq_set_wins", {31'b0, timer_irq}, 32'h1);
        cyc(1'b1, 4'b0001, 32'hbfaf0010, 32'h1);
        idle();
        #1 chk("irq_cleared", {31'b0, timer_irq}, 32'h0);
`else
        rd("timer_unmapped", 32'hbfaf0008, 32'h0);
        rd("cmp_unmapped", 32'hbfaf000c, 32'h0);
        idle();
        #1 chk("irq_tied0", {31'b0, timer_irq}, 32'h0);
`endif
        // reset asserted in the middle of an LED write
        cyc(1'b1, 4'b0011, 32'hbfaf0000, 32'h0000ffff);
        ram_rdata = 32'h77;
        cyc(1'b1, 4'b0011, 32'hbfaf0000, 32'h00005555);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_led", {16'b0, led}, 32'h0);
        chk("mid_rst_irq", {31'b0, timer_irq}, 32'h0);
        chk("mid_rst_rdata", cpu_rdata, 32'h77);
        @(posedge clk);
        #1 chk("rst_no_write", {16'b0, led}, 32'h0);
        reset = 1'b0;
        cpu_en = 1'b0;
`ifdef CONFREG_TIMER_EN
        rd("timer_restart", 32'hbfaf0008, 32'h1);
`else
        rd("timer_off_rst", 32'hbfaf0008, 32'h0);
`endif
        rd("ram_post_rst", 32'h1c000000, 32'h77);
        idle(); idle(); idle();
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
